nova_mem_ctl: RTL and testbench

//   Parametrised main memory for the NOVA core, replacing the flat combinational RAM.

---
 rtl/nova_mem_ctl_pkg.sv | 21 ++
 rtl/nova_mem_ctl_if.sv | 18 +
 rtl/nova_mem_array.sv | 24 ++
 rtl/nova_mem_ctl.sv | 149 ++++++++++++++
 tb/tb_nova_mem_ctl.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/nova_mem_ctl_pkg.sv
// Shared definitions for the NOVA main memory controller.
//   FSM state encodings and requester port ids, plus the wait-counter width.
// Optional feature macro: NOVA_MEM_PARITY_EN (see nova_mem_ctl.sv).
package nova_mem_ctl_pkg;

    localparam int WAIT_CNT_W = 4;  // WAIT_STATES range 0..15

    typedef enum logic [2:0] {
        NOVA_MEM_ST_INIT   = 3'd0,
        NOVA_MEM_ST_IDLE   = 3'd1,
        NOVA_MEM_ST_WAIT   = 3'd2,
        NOVA_MEM_ST_ACCESS = 3'd3,
        NOVA_MEM_ST_ACK    = 3'd4
    } mem_state_e;

    typedef enum logic {
        NOVA_MEM_PORT_CPU = 1'b0,
        NOVA_MEM_PORT_DCH = 1'b1
    } mem_port_e;

endpackage

// File: rtl/nova_mem_ctl_if.sv
// Requester bus for one memory port (CPU or data channel).
//   req/we/adr/din : driven by the requester (master), held until ack
//   ack            : one-cycle completion strobe from the memory (slave)
//   dout           : read data, valid while ack=1, otherwise 0
// Vectors use NOVA bit order: bit 0 is the MSB.
interface nova_mem_ctl_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  req;
    logic                  we;
    logic [0:15]           adr;
    logic [0:DATA_WIDTH-1] din;
    logic                  ack;
    logic [0:DATA_WIDTH-1] dout;

    modport master (output req, we, adr, din, input ack, dout);
    modport slave  (input req, we, adr, din, output ack, dout);
endinterface

// File: rtl/nova_mem_array.sv
// Single-port storage array: synchronous write, synchronous (registered) read.
//   clk  : clock
//   we   : write enable; din is written to adr on the edge
//   adr  : word address
//   din  : write data
//   dout : word at adr, registered on every edge (old data on a write edge)
// No reset: contents are cleared by the controller's init sweep.
module nova_mem_array #(
    parameter int WIDTH = 16,
    parameter int AW    = 15
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    adr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    logic [WIDTH-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (we) mem[adr] <= din;
        dout <= mem[adr];
    end
endmodule

// File: rtl/nova_mem_ctl.sv
// NOVA main memory controller: two requesters (CPU, DCH) over req/ack,
// DCH has fixed priority, WAIT_STATES extra cycles before each access,
// and a post-reset sweep that zero-fills the array before serving requests.
//   pclk, prst_n : clock, asynchronous active-low reset
//   cpu, dch     : requester buses (nova_mem_ctl_if.slave)
//   init_busy    : 1 while the zero-fill sweep runs
//   par_inj      : (NOVA_MEM_PARITY_EN) invert stored parity of the granted write
//   par_err      : (NOVA_MEM_PARITY_EN) parity mismatch on a read, with ack
// Define NOVA_MEM_PARITY_EN to add a stored even-parity bit per word.
module nova_mem_ctl
    import nova_mem_ctl_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 15,
    parameter int WAIT_STATES = 1
) (
    input  logic            pclk,
    input  logic            prst_n,
    nova_mem_ctl_if.slave   cpu,
    nova_mem_ctl_if.slave   dch,
    output logic            init_busy
`ifdef NOVA_MEM_PARITY_EN
    ,
    input  logic            par_inj,
    output logic            par_err
`endif
);
    localparam int AW = ADDR_WIDTH;
`ifdef NOVA_MEM_PARITY_EN
    localparam int ARR_W = DATA_WIDTH + 1;  // parity bit on top of the data
`else
    localparam int ARR_W = DATA_WIDTH;
`endif
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
        (WAIT_STATES > 0) ? WAIT_CNT_W'(WAIT_STATES - 1) : '0;

    mem_state_e            state_q, state_d;
    logic [AW-1:0]         sweep_q;
    logic [WAIT_CNT_W-1:0] wcnt_q;
    mem_port_e             lat_port;
    logic                  lat_we;
    logic [AW-1:0]         lat_adr;
    logic [ARR_W-1:0]      lat_din;

    logic                  any_req;
    logic                  sel_we;
    logic [AW-1:0]         sel_adr;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [ARR_W-1:0]      sel_word;

    logic                  arr_we;
    logic [AW-1:0]         arr_adr;
    logic [ARR_W-1:0]      arr_din;
    logic [ARR_W-1:0]      arr_dout;
    logic                  rd_ack;

    // Fixed-priority arbiter: DCH wins whenever it is requesting.
    // adr[16-AW:15] are the low AW bits; upper bits alias.
    assign any_req  = cpu.req | dch.req;
    assign sel_we   = dch.req ? dch.we : cpu.we;
    assign sel_adr  = dch.req ? dch.adr[16-AW:15] : cpu.adr[16-AW:15];
    assign sel_data = dch.req ? dch.din : cpu.din;
`ifdef NOVA_MEM_PARITY_EN
    assign sel_word = {(^sel_data) ^ par_inj, sel_data};
`else
    assign sel_word = sel_data;
`endif

    generate
        if (AW < 16) begin : g_adr_hi
            logic unused_adr_hi;
            assign unused_adr_hi = ^{cpu.adr[0:15-AW], dch.adr[0:15-AW]};
        end
    endgenerate

    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            state_q  <= NOVA_MEM_ST_INIT;
            sweep_q  <= '0;
            wcnt_q   <= '0;
            lat_port <= NOVA_MEM_PORT_CPU;
            lat_we   <= 1'b0;
            lat_adr  <= '0;
            lat_din  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == NOVA_MEM_ST_INIT) sweep_q <= sweep_q + 1'b1;
            if (state_q == NOVA_MEM_ST_IDLE && any_req) begin
                lat_port <= dch.req ? NOVA_MEM_PORT_DCH : NOVA_MEM_PORT_CPU;
                lat_we   <= sel_we;
                lat_adr  <= sel_adr;
                lat_din  <= sel_word;
                wcnt_q   <= WAIT_LOAD;
            end else if (state_q == NOVA_MEM_ST_WAIT && wcnt_q != '0) begin
                wcnt_q <= wcnt_q - 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        arr_we  = 1'b0;
        arr_adr = lat_adr;
        arr_din = lat_din;
        case (state_q)
            NOVA_MEM_ST_INIT: begin
                arr_we  = 1'b1;
                arr_adr = sweep_q;
                arr_din = '0;
                if (&sweep_q) state_d = NOVA_MEM_ST_IDLE;
            end
            NOVA_MEM_ST_IDLE:
                if (any_req)
                    state_d = (WAIT_STATES > 0) ? NOVA_MEM_ST_WAIT : NOVA_MEM_ST_ACCESS;
            NOVA_MEM_ST_WAIT:
                if (wcnt_q == '0) state_d = NOVA_MEM_ST_ACCESS;
            NOVA_MEM_ST_ACCESS: begin
                // Read data lands in the array's output register on this edge.
                arr_we  = lat_we;
                state_d = NOVA_MEM_ST_ACK;
            end
            NOVA_MEM_ST_ACK:  state_d = NOVA_MEM_ST_IDLE;
            default:          state_d = NOVA_MEM_ST_INIT;
        endcase
    end

    nova_mem_array #(
        .WIDTH (ARR_W),
        .AW    (AW)
    ) u_array (
        .clk  (pclk),
        .we   (arr_we),
        .adr  (arr_adr),
        .din  (arr_din),
        .dout (arr_dout)
    );

    // Outputs decode from registered state, so async reset clears them at once.
    assign init_busy = (state_q == NOVA_MEM_ST_INIT);
    assign rd_ack    = (state_q == NOVA_MEM_ST_ACK) && !lat_we;
    assign cpu.ack   = (state_q == NOVA_MEM_ST_ACK) && (lat_port == NOVA_MEM_PORT_CPU);
    assign dch.ack   = (state_q == NOVA_MEM_ST_ACK) && (lat_port == NOVA_MEM_PORT_DCH);
    assign cpu.dout  = (rd_ack && lat_port == NOVA_MEM_PORT_CPU) ? arr_dout[DATA_WIDTH-1:0] : '0;
    assign dch.dout  = (rd_ack && lat_port == NOVA_MEM_PORT_DCH) ? arr_dout[DATA_WIDTH-1:0] : '0;
`ifdef NOVA_MEM_PARITY_EN
    assign par_err   = rd_ack && ((^arr_dout[DATA_WIDTH-1:0]) != arr_dout[DATA_WIDTH]);
`endif

endmodule

// File: tb/tb_nova_mem_ctl.sv
// Self-checking bench for nova_mem_ctl (DATA_WIDTH=16, ADDR_WIDTH=12, WAIT_STATES=1).
// Table-driven directed vectors, hand sequences for arbitration, back-to-back,
// mid-access reset and held-during-init requests, then random traffic checked
// against a sparse word-addressed memory model. Parity checks are built when
// NOVA_MEM_PARITY_EN is defined.
module tb_nova_mem_ctl;
    localparam int DW    = 16;
    localparam int AW    = 12;
    localparam int WS    = 1;
    localparam int DEPTH = 1 << AW;
    localparam int LAT   = WS + 2;

    logic clk = 1'b0;
    logic rst_n;
    logic init_busy;
`ifdef NOVA_MEM_PARITY_EN
    logic par_inj;
    logic par_err;
`endif

    nova_mem_ctl_if #(.DATA_WIDTH(DW)) cpu_if ();
    nova_mem_ctl_if #(.DATA_WIDTH(DW)) dch_if ();

    nova_mem_ctl #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .WAIT_STATES (WS)
    ) dut (
        .pclk      (clk),
        .prst_n    (rst_n),
        .cpu       (cpu_if),
        .dch       (dch_if),
        .init_busy (init_busy)
`ifdef NOVA_MEM_PARITY_EN
        ,
        .par_inj   (par_inj),
        .par_err   (par_err)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [15:0] model [int];

    function automatic logic [15:0] model_rd(input logic [15:0] adr);
        int k = int'(adr) % DEPTH;
        return model.exists(k) ? model[k] : 16'h0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One transaction from an IDLE controller; returns read data and latency in edges.
    task automatic op(input bit use_dch, input bit we, input logic [15:0] adr,
                      input logic [15:0] din, input bit inj,
                      output logic [15:0] rd, output bit perr, output int lat);
        int n = 0;
        bit got = 0;
        @(negedge clk);
        if (use_dch) begin
            dch_if.req = 1; dch_if.we = we; dch_if.adr = adr; dch_if.din = din;
        end else begin
            cpu_if.req = 1; cpu_if.we = we; cpu_if.adr = adr; cpu_if.din = din;
        end
`ifdef NOVA_MEM_PARITY_EN
        par_inj = inj;
`endif
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            got = use_dch ? dch_if.ack : cpu_if.ack;
        end
        rd = use_dch ? dch_if.dout : cpu_if.dout;
`ifdef NOVA_MEM_PARITY_EN
        perr = par_err;
        par_inj = 0;
`else
        perr = inj & 1'b0;
`endif
        if (got) chk("other_port_ack", {31'd0, use_dch ? cpu_if.ack : dch_if.ack}, 0);
        else     chk("ack_timeout", 0, 1);
        cpu_if.req = 0; dch_if.req = 0;
        if (we) model[int'(adr) % DEPTH] = din;
        lat = n;
    endtask

    // Transaction checked against the model: latency, read data / zero dout on writes.
    task automatic run(input bit use_dch, input bit we, input logic [15:0] adr,
                       input logic [15:0] din, input string tag);
        logic [15:0] rd, exp;
        bit perr;
        int lat;
        exp = we ? 16'h0 : model_rd(adr);
        op(use_dch, we, adr, din, 1'b0, rd, perr, lat);
        chk({tag, "_lat"}, lat, LAT);
        chk({tag, "_dout"}, {16'd0, rd}, {16'd0, exp});
    endtask

    // Reset pulse and sweep; optionally a CPU read held high across the sweep.
    task automatic reset_init(input bit hold_rd, input logic [15:0] hadr);
        int k = 0;
        int early = 0;
        int ack_at = -1;
        rst_n = 0;
        #1;
        chk("rst_init_busy", {31'd0, init_busy}, 1);
        chk("rst_acks", {30'd0, cpu_if.ack, dch_if.ack}, 0);
        chk("rst_douts", {cpu_if.dout, dch_if.dout}, 0);
        model.delete();
        repeat (2) @(negedge clk);
        rst_n = 1;
        if (hold_rd) begin
            cpu_if.req = 1; cpu_if.we = 0; cpu_if.adr = hadr;
        end
        while (init_busy && k < DEPTH + 16) begin
            @(negedge clk);
            k++;
            if (cpu_if.ack && init_busy) early++;
        end
        chk("init_busy_cycles", k, DEPTH);
        if (hold_rd) begin
            chk("ack_during_init", early, 0);
            for (int i = 1; i <= LAT + 4 && ack_at < 0; i++) begin
                @(negedge clk);
                if (cpu_if.ack) begin
                    ack_at = i;
                    chk("held_rd_dout", {16'd0, cpu_if.dout}, {16'd0, model_rd(hadr)});
                end
            end
            chk("held_rd_latency", ack_at, LAT);
            cpu_if.req = 0;
        end
    endtask

    typedef struct {
        bit          dch;
        bit          we;
        logic [15:0] adr;
        logic [15:0] din;
        logic [15:0] exp;
    } vec_t;

    initial begin
        vec_t vecs[11];
        logic [15:0] rd;
        bit perr;
        int lat;
        int first_d, first_c, both;

        cpu_if.req = 0; cpu_if.we = 0; cpu_if.adr = 0; cpu_if.din = 0;
        dch_if.req = 0; dch_if.we = 0; dch_if.adr = 0; dch_if.din = 0;
`ifdef NOVA_MEM_PARITY_EN
        par_inj = 0;
`endif
        vecs = '{
            '{0, 1, 16'o100,  16'h1234, 16'h0000},
            '{0, 0, 16'o100,  16'h0000, 16'h1234},
            '{0, 1, 16'h8007, 16'hBEEF, 16'h0000},
            '{0, 0, 16'h0007, 16'h0000, 16'hBEEF},
            '{1, 0, 16'h1007, 16'h0000, 16'hBEEF},
            '{0, 0, 16'o1234, 16'h0000, 16'h0000},
            '{1, 1, 16'h0FFF, 16'hA5A5, 16'h0000},
            '{0, 0, 16'hFFFF, 16'h0000, 16'hA5A5},
            '{1, 1, 16'h0000, 16'hFFFF, 16'h0000},
            '{1, 0, 16'h0000, 16'h0000, 16'hFFFF},
            '{0, 0, 16'h0001, 16'h0000, 16'h0000}
        };

        #2;
        reset_init(1'b0, 16'h0);

        foreach (vecs[i]) begin
            op(vecs[i].dch, vecs[i].we, vecs[i].adr, vecs[i].din, 1'b0, rd, perr, lat);
            chk($sformatf("vec%0d_lat", i), lat, LAT);
            chk($sformatf("vec%0d_dout", i), {16'd0, rd}, {16'd0, vecs[i].exp});
        end

        // Simultaneous writes to 5: DCH served first, CPU data ends up stored.
        @(negedge clk);
        dch_if.req = 1; dch_if.we = 1; dch_if.adr = 16'd5; dch_if.din = 16'hAAAA;
        cpu_if.req = 1; cpu_if.we = 1; cpu_if.adr = 16'd5; cpu_if.din = 16'hBBBB;
        first_d = -1; first_c = -1; both = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (dch_if.ack && cpu_if.ack) both++;
            if (dch_if.ack && first_d < 0) begin first_d = i; dch_if.req = 0; end
            if (cpu_if.ack && first_c < 0) begin first_c = i; cpu_if.req = 0; end
        end
        chk("arb_dch_ack_at", first_d, LAT);
        chk("arb_cpu_ack_at", first_c, 2 * LAT + 1);
        chk("arb_both_acks", both, 0);
        model[5] = 16'hBBBB;
        run(1'b0, 1'b0, 16'd5, 16'h0, "arb_final_rd");

        // Back-to-back: held CPU read is served every WS+3 cycles.
        @(negedge clk);
        cpu_if.req = 1; cpu_if.we = 0; cpu_if.adr = 16'o100;
        first_c = -1; first_d = -1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (cpu_if.ack) begin
                if (first_c < 0) first_c = i;
                else if (first_d < 0) begin first_d = i; cpu_if.req = 0; end
                chk("b2b_dout", {16'd0, cpu_if.dout}, 32'h1234);
            end
        end
        chk("b2b_first_ack", first_c, LAT);
        chk("b2b_spacing", first_d - first_c, WS + 3);

`ifdef NOVA_MEM_PARITY_EN
        op(1'b0, 1'b1, 16'o20, 16'h0001, 1'b1, rd, perr, lat);
        op(1'b0, 1'b0, 16'o20, 16'h0000, 1'b0, rd, perr, lat);
        chk("par_inj_err", {31'd0, perr}, 1);
        chk("par_inj_data", {16'd0, rd}, 32'h0001);
        op(1'b0, 1'b1, 16'o21, 16'h0003, 1'b0, rd, perr, lat);
        op(1'b0, 1'b0, 16'o21, 16'h0000, 1'b0, rd, perr, lat);
        chk("par_clean_err", {31'd0, perr}, 0);
`endif

        // Random traffic; addresses reuse a small set of aliased words.
        for (int i = 0; i < 150; i++) begin
            logic [15:0] a;
            a = 16'($urandom_range(0, 7)) | (16'($urandom_range(0, 15)) << 12);
            run(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a,
                16'($urandom), $sformatf("rnd%0d", i));
        end

        // Write 0o10, then reset while a second write to 0o10 sits in WAIT.
        run(1'b0, 1'b1, 16'o10, 16'h5555, "pre_rst_wr");
        @(negedge clk);
        cpu_if.req = 1; cpu_if.we = 1; cpu_if.adr = 16'o10; cpu_if.din = 16'h7777;
        @(negedge clk);
        cpu_if.req = 0;
        chk("wait_no_ack", {31'd0, cpu_if.ack}, 0);
        reset_init(1'b1, 16'o10);
        run(1'b1, 1'b0, 16'o10, 16'h0, "post_rst_rd");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
